rcv_timer_ctrl: RTL

RCV_TIMER_CTRL -- requirements
Module: rcv_timer_ctrl

---
 rtl/rcv_timer_ctrl_if.sv | 34 +++
 rtl/rcv_timer_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/rcv_timer_ctrl_if.sv
// rcv_timer_ctrl_if - bundle of the receiver timing controller's handshake
// and status signals.
//   Inputs to the controller : start_bit_detected, stop_bit, bit_period, data_size
//   Outputs of the controller: busy, shift_strobe, sbc_clear, sbc_enable,
//                              load_buffer, packet_done, framing_error
//   modport master : the environment (drives inputs, observes outputs)
//   modport slave  : the controller itself
interface rcv_timer_ctrl_if #(
  parameter int NUM_CNT_BITS = 4
);
  logic                    start_bit_detected;
  logic                    stop_bit;
  logic [NUM_CNT_BITS-1:0] bit_period;
  logic [3:0]              data_size;
  logic                    busy;
  logic                    shift_strobe;
  logic                    sbc_clear;
  logic                    sbc_enable;
  logic                    load_buffer;
  logic                    packet_done;
  logic                    framing_error;

  modport master (
    output start_bit_detected, stop_bit, bit_period, data_size,
    input  busy, shift_strobe, sbc_clear, sbc_enable, load_buffer,
           packet_done, framing_error
  );

  modport slave (
    input  start_bit_detected, stop_bit, bit_period, data_size,
    output busy, shift_strobe, sbc_clear, sbc_enable, load_buffer,
           packet_done, framing_error
  );
endinterface

// File: rtl/rcv_timer_ctrl.sv
// rcv_timer_ctrl - timing controller for a serial receiver.
// Waits for a start bit, then times floor(1.5*P) clocks to the middle of the
// first data bit, strobes each of D data bits at mid-bit, enables the stop-bit
// checker at the stop bit's mid-point and finally reports good/bad packet.
// Ports:
//   clk   : system clock, rising edge
//   n_rst : asynchronous active-low reset
//   bus   : rcv_timer_ctrl_if.slave (inputs start_bit_detected, stop_bit,
//           bit_period, data_size; registered outputs busy, shift_strobe,
//           sbc_clear, sbc_enable, load_buffer, packet_done, framing_error)
module rcv_timer_ctrl #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic           clk,
  input  logic           n_rst,
  rcv_timer_ctrl_if.slave bus
);
  localparam int CW = NUM_CNT_BITS + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CHECK} state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           r_start_last;
  logic [CW-1:0]           r_bit_last;
  logic [3:0]              r_bits;
  logic [3:0]              r_dsize;

  logic                    r_busy;
  logic                    r_shift_strobe;
  logic                    r_sbc_clear;
  logic                    r_sbc_enable;
  logic                    r_load_buffer;
  logic                    r_packet_done;
  logic                    r_framing_error;

  logic [NUM_CNT_BITS-1:0] w_p;
  logic [CW-1:0]           w_p_ext;
  logic [CW-1:0]           w_start_last;
  logic [CW-1:0]           w_bit_last;
  logic [3:0]              w_dsize;

  // Clamp and precompute terminal counts once, at the start edge.
  always_comb begin
    w_p          = (bus.bit_period < NUM_CNT_BITS'(2)) ? NUM_CNT_BITS'(2) : bus.bit_period;
    w_p_ext      = CW'(w_p);
    w_start_last = w_p_ext + (w_p_ext >> 1) - CW'(1);
    w_bit_last   = w_p_ext - CW'(1);
    w_dsize      = (bus.data_size == 4'd0) ? 4'd1 : bus.data_size;
  end

  // Outputs are registered from the current state, so every pulse appears
  // one cycle after the state/count condition that produces it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_start_last    <= '0;
      r_bit_last      <= '0;
      r_bits          <= '0;
      r_dsize         <= '0;
      r_busy          <= 1'b0;
      r_shift_strobe  <= 1'b0;
      r_sbc_clear     <= 1'b0;
      r_sbc_enable    <= 1'b0;
      r_load_buffer   <= 1'b0;
      r_packet_done   <= 1'b0;
      r_framing_error <= 1'b0;
    end else begin
      r_shift_strobe <= 1'b0;
      r_sbc_clear    <= 1'b0;
      r_sbc_enable   <= 1'b0;
      r_load_buffer  <= 1'b0;
      r_packet_done  <= 1'b0;
      r_busy         <= (r_state != IDLE);

      case (r_state)
        IDLE: begin
          if (bus.start_bit_detected) begin
            r_start_last <= w_start_last;
            r_bit_last   <= w_bit_last;
            r_dsize      <= w_dsize;
            r_cnt        <= '0;
            r_bits       <= '0;
            r_state      <= START;
          end
        end
        START: begin
          if (r_cnt == '0) begin
            r_sbc_clear     <= 1'b1;
            r_framing_error <= 1'b0;
          end
          if (r_cnt == r_start_last) begin
            r_cnt          <= '0;
            r_shift_strobe <= 1'b1;
            r_bits         <= r_bits + 4'd1;
            r_state        <= (r_dsize == 4'd1) ? STOP : DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DATA: begin
          if (r_cnt == r_bit_last) begin
            r_cnt          <= '0;
            r_shift_strobe <= 1'b1;
            r_bits         <= r_bits + 4'd1;
            if (r_bits + 4'd1 == r_dsize) r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        STOP: begin
          if (r_cnt == r_bit_last) begin
            r_cnt        <= '0;
            r_sbc_enable <= 1'b1;
            r_state      <= CHECK;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        CHECK: begin
          r_packet_done <= 1'b1;
          if (bus.stop_bit) r_load_buffer   <= 1'b1;
          else              r_framing_error <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy          = r_busy;
  assign bus.shift_strobe  = r_shift_strobe;
  assign bus.sbc_clear     = r_sbc_clear;
  assign bus.sbc_enable    = r_sbc_enable;
  assign bus.load_buffer   = r_load_buffer;
  assign bus.packet_done   = r_packet_done;
  assign bus.framing_error = r_framing_error;
endmodule
